// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector with runtime-programmable
// pattern and overlap mode, input-valid qualifier and saturating match counter.
module seq_detect_param #(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 4'b1011,
  parameter logic             DEF_OVERLAP = 1'b1,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inp_bit,
  input  logic             inp_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             clr_count,
  output logic             seq_seen,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pattern;
  logic              overlap;
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill_inc;
  logic              accept;
  logic              match;
  logic [CNT_W-1:0]  count_nxt;

  // Next history/fill for an accepted bit, match detection and next counter value.
  always_comb begin
    accept    = inp_valid && !cfg_load;
    hist_nxt  = {hist[PAT_W-2:0], inp_bit};
    fill_inc  = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    match     = accept && (fill_inc == FILL_FULL) && (hist_nxt == pattern);
    count_nxt = match_count;
    if (clr_count)
      count_nxt = '0;
    else if (match && (match_count != '1))
      count_nxt = match_count + CNT_W'(1);
  end

  // Configuration, shift history, fill tracking, match pulse and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern     <= DEF_PATTERN;
      overlap     <= DEF_OVERLAP;
      hist        <= '0;
      fill        <= '0;
      seq_seen    <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      seq_seen <= 1'b0;
      if (cfg_load) begin
        // Loading a new pattern restarts detection; the bit offered this cycle is dropped.
        pattern <= cfg_pattern;
        overlap <= cfg_overlap;
        fill    <= '0;
      end else if (inp_valid) begin
        hist     <= hist_nxt;
        fill     <= (match && !overlap) ? '0 : fill_inc;
        seq_seen <= match;
      end
      match_count <= count_nxt;
      count_sat   <= (count_nxt == '1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inp_bit = 1'b0;
  logic       inp_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic       cfg_overlap = 1'b0;
  logic       clr_count = 1'b0;

  logic       seq_seen;
  logic [7:0] match_count;
  logic       count_sat;
  logic       seq_seen2;
  logic [1:0] match_count2;
  logic       count_sat2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .reset(reset), .inp_bit(inp_bit), .inp_valid(inp_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .seq_seen(seq_seen), .match_count(match_count),
    .count_sat(count_sat)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .inp_bit(inp_bit), .inp_valid(inp_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .seq_seen(seq_seen2), .match_count(match_count2),
    .count_sat(count_sat2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus driven at the falling edge; outputs sampled 1 ns after the rising edge.
  task automatic step(input logic rst, input logic v, input logic b, input logic ld,
                      input logic clr, input logic [3:0] pat, input logic ov);
    @(negedge clk);
    reset = rst; inp_valid = v; inp_bit = b; cfg_load = ld;
    clr_count = clr; cfg_pattern = pat; cfg_overlap = ov;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    step(1'b0, 1'b1, b, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  // Feed n bits (MSB first) and compare seq_seen after each against the expected pulse map.
  task automatic run_bits(input string tag, input logic [15:0] bits,
                          input logic [15:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      bit_in(bits[n-1-i]);
      check($sformatf("%s_bit%0d", tag, i + 1), {31'b0, seq_seen}, {31'b0, exp[n-1-i]});
    end
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("rst_seen", {31'b0, seq_seen}, 32'd0);
    check("rst_count", {24'b0, match_count}, 32'd0);
    check("rst_sat", {31'b0, count_sat}, 32'd0);
    check("rst_fill", {29'b0, dut.fill}, 32'd0);

    // Defaults: 1011 overlapping
    run_bits("ovl", 16'b1011011, 16'b0001001, 7);
    check("ovl_count", {24'b0, match_count}, 32'd2);

    // Non-overlapping 1011, counter cleared alongside the load
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0);
    check("load_clr_count", {24'b0, match_count}, 32'd0);
    run_bits("novl", 16'b1011011, 16'b0001000, 7);
    check("novl_count", {24'b0, match_count}, 32'd1);

    // Pattern 0000 overlapping: three consecutive pulses
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1);
    run_bits("zero", 16'b000000, 16'b000111, 6);
    check("zero_count", {24'b0, match_count}, 32'd3);

    // Defaults with inp_valid gaps of two cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    begin
      logic [3:0] gb;
      gb = 4'b1011;
      for (int i = 0; i < 4; i++) begin
        bit_in(gb[3-i]);
        check($sformatf("gap_bit%0d", i + 1), {31'b0, seq_seen}, (i == 3) ? 32'd1 : 32'd0);
        for (int g = 0; g < 2; g++) begin
          idle();
          check($sformatf("gap_idle%0d_%0d", i + 1, g), {31'b0, seq_seen}, 32'd0);
        end
      end
    end
    check("gap_count", {24'b0, match_count}, 32'd1);

    // CNT_W=2 saturation on the second instance
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    for (int r = 0; r < 5; r++) begin
      run_bits($sformatf("sat_rep%0d", r), 16'b1011, 16'b0001, 4);
      check($sformatf("sat_seen2_rep%0d", r), {31'b0, seq_seen2}, 32'd1);
      check($sformatf("sat_count_rep%0d", r), {30'b0, match_count2}, (r < 3) ? r + 1 : 3);
      check($sformatf("sat_flag_rep%0d", r), {31'b0, count_sat2}, (r >= 2) ? 32'd1 : 32'd0);
    end
    check("wide_count", {24'b0, match_count}, 32'd5);
    check("wide_sat", {31'b0, count_sat}, 32'd0);
    // clr_count coinciding with a match
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
    check("clr_seen2", {31'b0, seq_seen2}, 32'd1);
    check("clr_count2", {30'b0, match_count2}, 32'd0);
    check("clr_sat2", {31'b0, count_sat2}, 32'd0);

    // Reset mid-sequence discards partial history
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("midrst_count", {24'b0, match_count}, 32'd0);
    bit_in(1'b1);
    check("midrst_seen", {31'b0, seq_seen}, 32'd0);
    check("midrst_fill", {29'b0, dut.fill}, 32'd1);

    // cfg_load on the 4th bit of 1011 drops the bit and restarts fill
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    check("preload_hist", {28'b0, dut.hist}, 32'hD);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b1);
    check("load_seen", {31'b0, seq_seen}, 32'd0);
    check("load_fill", {29'b0, dut.fill}, 32'd0);
    check("load_hist", {28'b0, dut.hist}, 32'hD);
    check("load_count", {24'b0, match_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
